// File: rtl/node_pkg.sv
// node_pkg: shared widths, start/target node constants and FSM state encoding for node_sched.
package node_pkg;
  localparam int NODE_IDX_WIDTH  = 10;
  localparam int COUNTER_WIDTH   = 4;
  localparam int ACCUM_VAL_WIDTH = 24;
  localparam int FIFO_DEPTH      = 32;
  localparam int START_NODE_P1   = 0;
  localparam int START_NODE_P2   = 1;
  localparam int TARGET_NODE     = 2;
  typedef enum logic [2:0] {S_IDLE, S_POP, S_FETCH, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/node_fifo.sv
// node_fifo: power-of-two work queue; i_clr empties it and may load i_din as the sole entry.
module node_fifo
  import node_pkg::*;
#(
  parameter int W = NODE_IDX_WIDTH,
  parameter int D = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW   = $clog2(D);
  localparam int CNTW = AW + 1;
  logic [W-1:0]    r_mem [D];
  logic [AW-1:0]   r_wr, r_rd, w_wa;
  logic [CNTW-1:0] r_cnt;
  logic            w_push, w_pop, w_we;
  assign o_full  = r_cnt == CNTW'(D);
  assign o_empty = r_cnt == '0;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign w_we    = i_push && (i_clr || !o_full);
  assign w_wa    = i_clr ? '0 : r_wr;
  always_ff @(posedge clk)
    if (w_we) r_mem[w_wa] <= i_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= AW'(i_push);
      r_rd  <= '0;
      r_cnt <= CNTW'(i_push);
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + CNTW'(w_push) - CNTW'(w_pop);
    end
endmodule

// File: rtl/node_sched.sv
// node_sched: queue-driven graph walker counting paths from a start node to the target node.
// Define NODE_SCHED_PERF_EN to add the saturating busy-cycle counter output perf_cycles.
module node_sched
  import node_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = NODE_IDX_WIDTH,
  parameter int PARAM_COUNTER_WIDTH   = COUNTER_WIDTH,
  parameter int PARAM_ACCUM_VAL_WIDTH = ACCUM_VAL_WIDTH,
  parameter int PARAM_FIFO_DEPTH      = FIFO_DEPTH,
  parameter int PARAM_START_NODE_P1   = START_NODE_P1,
  parameter int PARAM_START_NODE_P2   = START_NODE_P2,
  parameter int PARAM_TARGET_NODE     = TARGET_NODE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             part_sel,
  input  logic                             start_run,
  output logic                             mem_rd_en,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  mem_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]   mem_edge_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  mem_rd_data,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   mem_edge_count,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx_reg,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
  output logic                             busy,
  output logic                             done,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] path_count,
  output logic                             fifo_ovf
`ifdef NODE_SCHED_PERF_EN
  ,
  output logic [31:0]                      perf_cycles
`endif
);
  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int VW = PARAM_ACCUM_VAL_WIDTH;
  localparam logic [NW-1:0] L_P1     = NW'(PARAM_START_NODE_P1);
  localparam logic [NW-1:0] L_P2     = NW'(PARAM_START_NODE_P2);
  localparam logic [NW-1:0] L_TARGET = NW'(PARAM_TARGET_NODE);
  state_t        r_state;
  logic [NW-1:0] r_node, r_next, w_din, w_dout;
  logic [CW-1:0] r_cnt;
  logic [VW-1:0] r_paths;
  logic          r_rd_en, r_busy, r_done, r_ovf;
  logic          w_start, w_hit, w_wait_push, w_push, w_pop, w_last, w_full, w_empty;
  assign w_start     = start_run && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hit       = mem_rd_data == L_TARGET;
  assign w_wait_push = r_state == S_WAIT && mem_edge_count != '0 && !w_hit;
  assign w_push      = w_start || w_wait_push;
  assign w_din       = w_start ? (part_sel ? L_P2 : L_P1) : mem_rd_data;
  assign w_pop       = r_state == S_POP && !w_empty;
  assign w_last      = r_cnt + CW'(1) == mem_edge_count;
  node_fifo #(.W(NW), .D(PARAM_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // mem_rd_en is registered: raised on every transition into FETCH, dropped on the next edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_node  <= '0;
      r_next  <= '0;
      r_cnt   <= '0;
      r_paths <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE:
          if (start_run) begin
            r_paths <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_POP;
          end
        S_POP:
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_node  <= w_dout;
            r_cnt   <= '0;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT:
          if (mem_edge_count == '0) r_state <= S_POP;
          else begin
            r_next <= mem_rd_data;
            if (w_hit && r_paths != '1) r_paths <= r_paths + VW'(1);
            if (!w_hit && w_full) r_ovf <= 1'b1;
            if (w_last) r_state <= S_POP;
            else begin
              r_cnt   <= r_cnt + CW'(1);
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        default: r_state <= S_IDLE;
      endcase
    end
  assign mem_rd_en         = r_rd_en;
  assign mem_node_idx      = r_node;
  assign mem_edge_idx      = r_cnt;
  assign node_idx_reg      = r_node;
  assign next_node_idx     = r_next;
  assign next_node_counter = r_cnt;
  assign busy              = r_busy;
  assign done              = r_done;
  assign path_count        = r_paths;
  assign fifo_ovf          = r_ovf;
`ifdef NODE_SCHED_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_perf <= '0;
    else if (w_start) r_perf <= '0;
    else if (r_busy && r_perf != '1) r_perf <= r_perf + 32'd1;
  assign perf_cycles = r_perf;
`endif
endmodule

// File: tb/tb_node_sched.sv
// tb_node_sched: table-driven and randomized checks of node_sched against a queue-based path model.
module tb_node_sched;
  logic       clk = 1'b0, rst_n = 1'b0, part_sel = 1'b0, start_run = 1'b0;
  logic       mem_rd_en, busy, done, fifo_ovf;
  logic [9:0] mem_node_idx, mem_rd_data, node_idx_reg, next_node_idx;
  logic [3:0] mem_edge_idx, mem_edge_count, next_node_counter;
  logic [23:0] path_count;
  logic       s_rd_en, s_busy, s_done, s_ovf;
  logic [9:0] s_node_idx, s_rd_data, s_node_reg, s_next_idx;
  logic [3:0] s_edge_idx, s_edge_count, s_next_cnt;
  logic [1:0] s_path_count;
`ifdef NODE_SCHED_PERF_EN
  logic [31:0] perf_cycles, s_perf;
`endif

  node_sched dut (
    .clk(clk), .rst_n(rst_n), .part_sel(part_sel), .start_run(start_run),
    .mem_rd_en(mem_rd_en), .mem_node_idx(mem_node_idx), .mem_edge_idx(mem_edge_idx),
    .mem_rd_data(mem_rd_data), .mem_edge_count(mem_edge_count),
    .node_idx_reg(node_idx_reg), .next_node_idx(next_node_idx),
    .next_node_counter(next_node_counter), .busy(busy), .done(done),
    .path_count(path_count), .fifo_ovf(fifo_ovf)
`ifdef NODE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // narrow-accumulator instance: exposes saturation within a short run
  node_sched #(.PARAM_ACCUM_VAL_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .part_sel(part_sel), .start_run(start_run),
    .mem_rd_en(s_rd_en), .mem_node_idx(s_node_idx), .mem_edge_idx(s_edge_idx),
    .mem_rd_data(s_rd_data), .mem_edge_count(s_edge_count),
    .node_idx_reg(s_node_reg), .next_node_idx(s_next_idx),
    .next_node_counter(s_next_cnt), .busy(s_busy), .done(s_done),
    .path_count(s_path_count), .fifo_ovf(s_ovf)
`ifdef NODE_SCHED_PERF_EN
    , .perf_cycles(s_perf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned deg [1024];
  logic [9:0]  adj [1024][16];
  int          exp_rd[$];
  int          checks = 0, errors = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data    <= adj[mem_node_idx][mem_edge_idx];
      mem_edge_count <= 4'(deg[mem_node_idx]);
    end
    if (s_rd_en) begin
      s_rd_data    <= adj[s_node_idx][s_edge_idx];
      s_edge_count <= 4'(deg[s_node_idx]);
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ":outs_a"}, {mem_rd_en, mem_node_idx, mem_edge_idx, node_idx_reg, next_node_idx}, 0);
    chk({nm, ":outs_b"}, {next_node_counter, busy, done, path_count, fifo_ovf}, 0);
    chk({nm, ":sat_outs"}, {s_rd_en, s_node_reg, s_next_idx, s_next_cnt, s_busy, s_done, s_path_count, s_ovf}, 0);
  endtask

  task automatic add(input int s, input int d);
    adj[s][deg[s]] = 10'(d);
    deg[s]++;
  endtask

  task automatic clear_graph();
    for (int i = 0; i < 1024; i++) deg[i] = 0;
  endtask

  task automatic build_graph(input int g);
    int l;
    clear_graph();
    case (g)
      1: add(0, 2);
      2: begin add(0, 3); add(0, 4); add(3, 2); add(4, 2); add(4, 3); end
      4: begin
        l = 100;
        for (int i = 0; i < 4; i++) add(0, 10 + i);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) add(10 + i, 20 + 4 * i + j);
        for (int k = 0; k < 16; k++) for (int j = 0; j < (k < 8 ? 3 : 2); j++) begin add(20 + k, l); l++; end
      end
      5: repeat (5) add(0, 2);
      default: ;
    endcase
  endtask

  task automatic rand_graph();
    int n;
    clear_graph();
    for (int i = 0; i < 7; i++) begin
      n = $urandom_range(0, 3);
      for (int e = 0; e < n; e++) add(i, $urandom_range(i + 1, 7));
    end
  endtask

  // Breadth-first expansion with a 32-entry queue; each popped node costs one cycle plus two per edge slot.
  task automatic model(input bit part, output longint paths, output bit ovf, output int cyc);
    int q[$];
    int n, d;
    q.delete();
    exp_rd.delete();
    paths = 0;
    ovf = 0;
    cyc = 2;
    q.push_back(part ? 1 : 0);
    while (q.size() > 0) begin
      n = q.pop_front();
      cyc += 1 + 2 * (deg[n] == 0 ? 1 : int'(deg[n]));
      if (deg[n] == 0) exp_rd.push_back(n * 16);
      for (int e = 0; e < int'(deg[n]); e++) begin
        exp_rd.push_back(n * 16 + e);
        d = int'(adj[n][e]);
        if (d == 2) paths = (paths == 24'hFFFFFF) ? paths : paths + 1;
        else if (q.size() >= 32) ovf = 1;
        else q.push_back(d);
      end
    end
  endtask

  task automatic do_run(input bit part, input longint ep, input longint es, input bit eo,
                        input int ecyc, input string nm, input int restart_at);
    int c, first, ri, bad;
    first = -1;
    ri = 0;
    bad = 0;
    @(negedge clk);
    part_sel = part;
    start_run = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    c = 1;
    chk({nm, ":busy_start"}, busy, 1);
    while (!done && c < ecyc + 20) begin
      if (mem_rd_en) begin
        if (first < 0) first = c;
        if (ri >= exp_rd.size() || {mem_node_idx, mem_edge_idx} != 14'(exp_rd[ri])) bad++;
        ri++;
      end
      if (restart_at != 0 && c == restart_at) begin
        start_run = 1'b1;
        part_sel = ~part;
      end else start_run = 1'b0;
      @(negedge clk);
      c++;
    end
    start_run = 1'b0;
    chk({nm, ":done"}, done, 1);
    chk({nm, ":done_cycle"}, c, ecyc);
    chk({nm, ":first_rd"}, first, 2);
    chk({nm, ":rd_mismatches"}, bad, 0);
    chk({nm, ":rd_count"}, ri, exp_rd.size());
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":path_count"}, path_count, ep);
    chk({nm, ":sat_path_count"}, s_path_count, es);
    chk({nm, ":fifo_ovf"}, fifo_ovf, eo);
`ifdef NODE_SCHED_PERF_EN
    chk({nm, ":perf"}, perf_cycles, c - 1);
`endif
    @(negedge clk);
    chk({nm, ":done_held"}, done, 1);
  endtask

  typedef struct {
    int    g;
    bit    part;
    int    paths;
    int    sat;
    bit    ovf;
    int    cyc;
    string nm;
  } vec_t;

  vec_t   tbl[5];
  longint mp;
  bit     mo;
  int     mc, k, tries;
  bit     pt;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1'b0, 1, 1, 1'b0, 5, "single_edge"};
    tbl[1] = '{2, 1'b0, 3, 3, 1'b0, 18, "diamond"};
    tbl[2] = '{2, 1'b1, 0, 0, 1'b0, 5, "dead_start"};
    tbl[3] = '{4, 1'b0, 0, 0, 1'b1, 0, "overflow"};
    tbl[4] = '{5, 1'b0, 5, 3, 1'b0, 13, "saturate"};
    clear_graph();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      build_graph(tbl[i].g);
      model(tbl[i].part, mp, mo, mc);
      do_run(tbl[i].part, tbl[i].paths, tbl[i].sat, tbl[i].ovf,
             tbl[i].cyc != 0 ? tbl[i].cyc : mc, tbl[i].nm, 0);
    end

    build_graph(2);
    model(1'b0, mp, mo, mc);
    do_run(1'b0, 3, 3, 1'b0, 18, "restart_ignored", 4);

    build_graph(2);
    model(1'b0, mp, mo, mc);
    @(negedge clk);
    part_sel = 1'b0;
    start_run = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    k = 0;
    while (path_count == 0 && k < 100) begin @(negedge clk); k++; end
    chk("rst_mid:count_seen", path_count, 1);
    while (!mem_rd_en && k < 200) begin @(negedge clk); k++; end
    chk("rst_mid:fetch_seen", mem_rd_en, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    do_run(1'b0, 3, 3, 1'b0, 18, "after_reset", 0);

    for (int r = 0; r < 15; r++) begin
      tries = 0;
      do begin
        rand_graph();
        pt = 1'($urandom_range(0, 1));
        model(pt, mp, mo, mc);
        tries++;
      end while (mc > 3000 && tries < 50);
      if (mc > 3000) begin
        build_graph(1);
        pt = 1'b0;
        model(pt, mp, mo, mc);
      end
      do_run(pt, mp, mp > 3 ? 3 : mp, mo, mc, "random", 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_sched.md
NODE_SCHED -- requirements
Module: node_sched

Interface
REQ-001 SHALL have parameter PARAM_NODE_IDX_WIDTH, default 10, node index width.
REQ-002 SHALL have parameter PARAM_COUNTER_WIDTH, default 4, edge-counter and edge-count width.
REQ-003 SHALL have parameter PARAM_ACCUM_VAL_WIDTH, default 24, path-count width.
REQ-004 SHALL have parameter PARAM_FIFO_DEPTH, default 32, work-queue depth in entries (power of two).
REQ-005 SHALL have parameters PARAM_START_NODE_P1 (default 0), PARAM_START_NODE_P2 (default 1) and PARAM_TARGET_NODE (default 2), which are the start node per part and the terminal node.
REQ-006 SHALL have the following ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- part_sel  in  1  0: start at P1 node, 1: start at P2 node; sampled with start_run.
- start_run  in  1  single-cycle start request.
- mem_rd_en  out  1  adjacency read strobe.
- mem_node_idx  out  NODE  node being read.
- mem_edge_idx  out  COUNTER  edge slot being read.
- mem_rd_data  in  NODE  neighbour index; valid the cycle after mem_rd_en.
- mem_edge_count  in  COUNTER  out-degree of mem_node_idx; valid with mem_rd_data.
- node_idx_reg  out  NODE  node currently being expanded.
- next_node_idx  out  NODE  last neighbour fetched.
- next_node_counter  out  COUNTER  current edge counter.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- path_count  out  ACCUM  number of paths that reached the target.
- fifo_ovf  out  1  sticky flag: a push was dropped.

Function
REQ-007 SHALL implement an FSM with states IDLE, POP, FETCH, WAIT and DONE.
REQ-008 In IDLE or DONE, start_run=1 SHALL:
- clear path_count, fifo_ovf and done;
- flush the FIFO;
- push the start node selected by part_sel;
- go to POP with busy=1.
REQ-009 POP, FIFO empty SHALL go to DONE with done=1 and busy=0. POP, FIFO not empty SHALL pop the head into node_idx_reg, zero next_node_counter and go to FETCH.
REQ-010 FETCH SHALL assert mem_rd_en for exactly one cycle, with mem_node_idx=node_idx_reg and mem_edge_idx=next_node_counter, then go to WAIT.
REQ-011 WAIT, mem_edge_count==0 SHALL go to POP with no push and no count.
REQ-012 WAIT, mem_edge_count!=0 SHALL capture next_node_idx=mem_rd_data, then:
- if mem_rd_data==PARAM_TARGET_NODE, increment path_count;
- otherwise push mem_rd_data into the FIFO.
REQ-013 After REQ-012, WAIT SHALL go to POP if next_node_counter+1==mem_edge_count; otherwise it SHALL increment next_node_counter and go to FETCH.
REQ-014 Each edge SHALL take exactly 2 cycles (FETCH, WAIT). The first mem_rd_en SHALL occur 2 cycles after the cycle in which start_run is sampled.
REQ-015 path_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-016 A push into a full FIFO SHALL be dropped and SHALL set fifo_ovf, which stays set until the next start. The run SHALL continue.
REQ-017 start_run in POP, FETCH or WAIT SHALL be ignored.
REQ-018 Push and pop SHALL never occur in the same cycle. FIFO pointers SHALL wrap modulo PARAM_FIFO_DEPTH.
REQ-019 mem_rd_en SHALL be 0 in every state other than FETCH.

Reset
REQ-020 rst_n=0 SHALL asynchronously force:
- state to IDLE;
- FIFO to empty;
- all outputs to 0.
This applies at any point, including mid-run.
REQ-021 The first start_run after rst_n deasserts SHALL behave as in REQ-008.

Configuration
REQ-022 With NODE_SCHED_PERF_EN defined, the block SHALL add output perf_cycles (32 bits, saturating). perf_cycles SHALL be cleared on start and count every cycle with busy=1.
REQ-023 Without NODE_SCHED_PERF_EN, the block SHALL omit the perf_cycles port and its counter. All other behaviour SHALL be unchanged.

Structure
REQ-024 Package node_pkg SHALL hold:
- the width parameters' defaults;
- the start and target node constants;
- the FSM state enum.
REQ-025 The FIFO SHALL be sub-module node_fifo, with push, pop, full, empty and dout ports, parameterised by width and depth.

Verification
REQ-026 Graph 0->{2}, part_sel=0, start_run -> mem_rd_en 2 cycles later; path_count=1; done=1 on cycle 5 after start.
REQ-027 Graph 0->{3,4}, 3->{2}, 4->{2,3} -> path_count=3, fifo_ovf=0.
REQ-028 part_sel=1, node 1 has out-degree 0 -> done with path_count=0 after POP, FETCH, WAIT, POP.
REQ-029 40 non-target leaves fanned out from 0 through 3 levels of depth-4 nodes, so the FIFO exceeds 32 entries -> fifo_ovf=1; run still reaches done.
REQ-030 rst_n pulsed low while in WAIT -> all outputs 0 immediately; a fresh start_run reproduces the REQ-027 result.
REQ-031 start_run pulsed while busy -> no effect on path_count or FIFO contents.
